// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM word-interleaving path (mux and demux sides).
// Holds the framing state encodings and the slot-index width helper.
package tdm_demux_pkg;

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   // Width of a slot index for a frame of numCh channels; never narrower than one bit.
   function automatic int chWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for the TDM demux.
// Tracks which channel slot the next incoming word belongs to.
// Supports clear (back to slot 0), load-1 (a start-of-frame word was just taken as slot 0)
// and increment, with flags for "at the last slot" and "expecting slot 0".
module tdm_slot_counter
   import tdm_demux_pkg::*;
#(
   parameter int CH_W = 2,
   parameter int LAST = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_i,
   input  logic            load1_i,
   input  logic            inc_i,
   output logic [CH_W-1:0] cnt_o,
   output logic            atLast_o,
   output logic            isZero_o
);

   localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(LAST);
   localparam logic [CH_W-1:0] ONE_SLOT  = CH_W'(1);

   logic [CH_W-1:0] cnt_q;
   logic [CH_W-1:0] cnt_d;

   // Next slot: clear wins over load-1, which wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load1_i) begin
         cnt_d = ONE_SLOT;
      end else if (inc_i) begin
         cnt_d = cnt_q + ONE_SLOT;
      end
   end

   // Slot register with synchronous reset back to slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign atLast_o = (cnt_q == LAST_SLOT);
   assign isZero_o = (cnt_q == '0);

endmodule

// File: rtl/tdm_demux.sv
// TDM word demultiplexer.
// Rebuilds NUM_CH parallel channel words from an interleaved word stream where channel 0
// is flagged by in_sof. Hunts for a start-of-frame, then receives frames while the stream
// stays aligned; any misplaced or missing start-of-frame raises a one-cycle sync_err.
// A completed frame is written into out_data in one shot and held until the next frame.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [WIDTH-1:0]        in_data,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic                    frame_valid,
   output logic                    sync_err,
   output logic                    locked,
   output logic [CNT_W-1:0]        frame_count
);

   localparam int              CH_W      = chWidth(NUM_CH);
   localparam logic [CNT_W-1:0] ONE_FRAME = CNT_W'(1);

   logic [0:0]              state_q,      state_d;
   logic [WIDTH-1:0]        shadow_q [NUM_CH];
   logic [WIDTH-1:0]        shadow_d [NUM_CH];
   logic [NUM_CH*WIDTH-1:0] outData_q,    outData_d;
   logic                    frameValid_q, frameValid_d;
   logic                    syncErr_q,    syncErr_d;
   logic [CNT_W-1:0]        frameCount_q, frameCount_d;

   logic [CH_W-1:0]         slot;
   logic                    slotAtLast;
   logic                    slotIsZero;
   logic                    slotClear;
   logic                    slotLoad1;
   logic                    slotInc;

   tdm_slot_counter #(
      .CH_W (CH_W),
      .LAST (NUM_CH - 1)
   ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (slotClear),
      .load1_i  (slotLoad1),
      .inc_i    (slotInc),
      .cnt_o    (slot),
      .atLast_o (slotAtLast),
      .isZero_o (slotIsZero)
   );

   // Framing decisions for the word on the input this cycle. Idle cycles leave everything
   // untouched and drop the one-cycle pulses. The last word of a frame goes straight to
   // the output register so the frame is visible the cycle after it completes.
   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      outData_d    = outData_q;
      frameValid_d = 1'b0;
      syncErr_d    = 1'b0;
      frameCount_d = frameCount_q;
      slotClear    = 1'b0;
      slotLoad1    = 1'b0;
      slotInc      = 1'b0;

      if (in_valid) begin
         if (state_q == ST_HUNT) begin
            if (in_sof) begin
               shadow_d[0] = in_data;
               slotLoad1   = 1'b1;
               state_d     = ST_RECV;
            end
         end else if (slotIsZero) begin
            if (in_sof) begin
               shadow_d[0] = in_data;
               slotLoad1   = 1'b1;
            end else begin
               syncErr_d = 1'b1;
               slotClear = 1'b1;
               state_d   = ST_HUNT;
            end
         end else if (!in_sof) begin
            shadow_d[slot] = in_data;
            if (slotAtLast) begin
               for (int i = 0; i < NUM_CH - 1; i++) begin
                  outData_d[i*WIDTH +: WIDTH] = shadow_q[i];
               end
               outData_d[(NUM_CH-1)*WIDTH +: WIDTH] = in_data;
               frameValid_d = 1'b1;
               frameCount_d = frameCount_q + ONE_FRAME;
               slotClear    = 1'b1;
            end else begin
               slotInc = 1'b1;
            end
         end else begin
            syncErr_d   = 1'b1;
            shadow_d[0] = in_data;
            slotLoad1   = 1'b1;
         end
      end
   end

   // State, shadow and output registers; reset discards any partial frame and clears outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_HUNT;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
         end
         outData_q    <= '0;
         frameValid_q <= 1'b0;
         syncErr_q    <= 1'b0;
         frameCount_q <= '0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         outData_q    <= outData_d;
         frameValid_q <= frameValid_d;
         syncErr_q    <= syncErr_d;
         frameCount_q <= frameCount_d;
      end
   end

   assign out_data    = outData_q;
   assign frame_valid = frameValid_q;
   assign sync_err    = syncErr_q;
   assign locked      = (state_q == ST_RECV);
   assign frame_count = frameCount_q;

endmodule
